fetch_sequencer: RTL

Instruction-fetch and next-PC stage directly upstream of the execute datapath. Owns the PC register and fetches each instruction from instruction memory through a variable-latency request/valid handshake. Holds that instruction stable for exactly one execute cycle. Resolves branches and jumps from the datapath's comparator flags and ALU result, and supplies `PC_out`, `inc_PC` and a one-cycle commit strobe.

---
 rtl/fetch_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : fetch_sequencer
// Purpose : PC owner, variable-latency instruction fetch, one-cycle execute
//           strobe and branch/jump next-PC resolution.
// Revision: 1.0 - initial release
// ============================================================================
module fetch_sequencer #(
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               trigger,
    output logic               imem_req,
    output logic [D_WIDTH-1:0] imem_addr,
    input  logic               imem_valid,
    input  logic [D_WIDTH-1:0] imem_rdata,
    output logic [D_WIDTH-1:0] instr,
    output logic               exec_en,
    input  logic               Branch,
    input  logic               Jump,
    input  logic               JumpReg,
    input  logic [2:0]         funct3,
    input  logic               Zero,
    input  logic               Less,
    input  logic               LessU,
    input  logic [D_WIDTH-1:0] ImmExt,
    input  logic [D_WIDTH-1:0] ALUout,
    output logic [D_WIDTH-1:0] PC_out,
    output logic [D_WIDTH-1:0] inc_PC,
    output logic               misalign,
    output logic [D_WIDTH-1:0] instret
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [D_WIDTH-1:0] c_FOUR   = {{(D_WIDTH-3){1'b0}}, 3'd4};
    localparam logic [D_WIDTH-1:0] c_ONE    = {{(D_WIDTH-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [D_WIDTH-1:0] r_pc;
    logic [D_WIDTH-1:0] r_instr;
    logic [D_WIDTH-1:0] r_instret;
    logic               r_misalign;
    logic               r_exec_en;
    logic               r_imem_req;
    logic               w_taken;
    logic [D_WIDTH-1:0] w_inc_pc;
    logic [D_WIDTH-1:0] w_rel_tgt;
    logic [D_WIDTH-1:0] w_jalr_tgt;
    logic [D_WIDTH-1:0] w_next_pc;
    logic               w_misaligned;

    assign w_inc_pc   = r_pc + c_FOUR;
    assign w_rel_tgt  = r_pc + ImmExt;
    assign w_jalr_tgt = ALUout & ~c_ONE;

    always_comb begin
        w_taken = 1'b0;
        case (funct3)
            3'b000:  w_taken = Zero;
            3'b001:  w_taken = !Zero;
            3'b100:  w_taken = Less;
            3'b101:  w_taken = !Less;
            3'b110:  w_taken = LessU;
            3'b111:  w_taken = !LessU;
            default: w_taken = 1'b0;
        endcase
    end

    always_comb begin
        w_next_pc = w_inc_pc;
        if (JumpReg)
            w_next_pc = w_jalr_tgt;
        else if (Jump)
            w_next_pc = w_rel_tgt;
        else if (Branch && w_taken)
            w_next_pc = w_rel_tgt;
    end

    assign w_misaligned = |w_next_pc[1:0];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (trigger) w_state_nxt = S_FETCH;
            S_FETCH: if (imem_valid) w_state_nxt = S_EXEC;
            S_EXEC: begin
                if (w_misaligned)
                    w_state_nxt = S_HALT;
                else if (trigger)
                    w_state_nxt = S_FETCH;
                else
                    w_state_nxt = S_IDLE;
            end
            S_HALT:  w_state_nxt = S_HALT;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so they never glitch on a
    // multi-bit state transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_exec_en  <= 1'b0;
            r_imem_req <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_exec_en  <= (w_state_nxt == S_EXEC);
            r_imem_req <= (w_state_nxt == S_FETCH);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= '0;
            r_instret  <= '0;
            r_misalign <= 1'b0;
        end else begin
            if (r_state == S_FETCH && imem_valid)
                r_instr <= imem_rdata;
            if (r_state == S_EXEC) begin
                r_instret <= r_instret + c_ONE;
                if (w_misaligned)
                    r_misalign <= 1'b1;
                else
                    r_pc <= w_next_pc;
            end
        end
    end

    assign imem_req  = r_imem_req;
    assign imem_addr = r_pc;
    assign instr     = r_instr;
    assign exec_en   = r_exec_en;
    assign PC_out    = r_pc;
    assign inc_PC    = w_inc_pc;
    assign misalign  = r_misalign;
    assign instret   = r_instret;

endmodule
`default_nettype wire
